// File: rtl/icache_cmd_dispatch_if.sv
// Trace-record input and L1 instruction-cache command bus for icache_cmd_dispatch.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready on the trace side, c_write/c_processing on the cache side.
interface icache_cmd_dispatch_if;
  // trace record side
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_code;
  logic [59:0] in_addr;
  // cache command side
  logic        c_write;
  logic [2:0]  c_command;
  logic [59:0] c_address;
  logic        c_processing;

  // Environment: produces trace records and plays the cache.
  modport master (
    output in_valid, in_code, in_addr, c_processing,
    input  in_ready, c_write, c_command, c_address
  );

  // Dispatcher: consumes trace records and drives cache commands.
  modport slave (
    input  in_valid, in_code, in_addr, c_processing,
    output in_ready, c_write, c_command, c_address
  );
endinterface

// File: rtl/icache_cmd_dispatch.sv
// Buffers trace records in a FIFO, maps them to L1 icache commands and issues them one at a time.
// Latency: record at FIFO head is popped in IDLE; c_write rises the next cycle; >=4 cycles per command.
// Backpressure: in_ready = !full from the registered count; cache busy (c_processing) holds off pops.
module icache_cmd_dispatch #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  icache_cmd_dispatch_if.slave     bus,
  output logic                     print_req,
  output logic [31:0]              issued_cnt,
  output logic [31:0]              dropped_cnt,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     idle,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_HALT      = 3'd4;

  localparam logic [3:0] CODE_READ  = 4'd2;
  localparam logic [3:0] CODE_CLEAR = 4'd8;
  localparam logic [3:0] CODE_PRINT = 4'd9;

  localparam logic [2:0] CMD_READ  = 3'd0;
  localparam logic [2:0] CMD_CLEAR = 3'd3;

  logic [3:0]    code_mem [DEPTH];
  logic [59:0]   addr_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic          c_write_q;
  logic [2:0]    c_command_q;
  logic [59:0]   c_address_q;

  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [3:0]    head_code;
  logic [59:0]   head_addr;
  logic          timer_expired;

  assign fifo_full     = (fifo_count == CW'(DEPTH));
  assign fifo_empty    = (fifo_count == '0);
  assign bus.in_ready  = !fifo_full;
  assign push          = bus.in_valid && !fifo_full;
  // Only the dispatcher pops, and only while the cache is not busy.
  assign pop           = (state == S_IDLE) && !fifo_empty && !bus.c_processing;
  assign head_code     = code_mem[rd_ptr];
  assign head_addr     = addr_mem[rd_ptr];
  assign timer_expired = (timer == TW'(TIMEOUT - 1));

  assign bus.c_write   = c_write_q;
  assign bus.c_command = c_command_q;
  assign bus.c_address = c_address_q;
  assign idle          = (state == S_IDLE) && fifo_empty;

  // FIFO storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      code_mem[wr_ptr] <= bus.in_code;
      addr_mem[wr_ptr] <= bus.in_addr;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally with power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Dispatch FSM: decode head record, strobe the cache, then track ack/completion with a watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      c_write_q   <= 1'b0;
      c_command_q <= 3'd0;
      c_address_q <= 60'd0;
      print_req   <= 1'b0;
      issued_cnt  <= 32'd0;
      dropped_cnt <= 32'd0;
      timeout_err <= 1'b0;
    end else begin
      print_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            case (head_code)
              CODE_READ: begin
                c_command_q <= CMD_READ;
                c_address_q <= head_addr;
                c_write_q   <= 1'b1;
                state       <= S_ISSUE;
              end
              CODE_CLEAR: begin
                c_command_q <= CMD_CLEAR;
                c_address_q <= head_addr;
                c_write_q   <= 1'b1;
                state       <= S_ISSUE;
              end
              CODE_PRINT: print_req   <= 1'b1;
              default:    dropped_cnt <= dropped_cnt + 32'd1;
            endcase
          end
        end
        S_ISSUE: begin
          // The cache samples the strobe on this edge; it lasts exactly one cycle.
          c_write_q  <= 1'b0;
          issued_cnt <= issued_cnt + 32'd1;
          timer      <= '0;
          state      <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // Timer counts every cycle spent waiting, across both wait states.
          timer <= timer + 1'b1;
          if (bus.c_processing) begin
            state <= S_WAIT_DONE;
          end else if (timer_expired) begin
            timeout_err <= 1'b1;
            state       <= S_HALT;
          end
        end
        S_WAIT_DONE: begin
          timer <= timer + 1'b1;
          if (!bus.c_processing) begin
            state <= S_IDLE;
          end else if (timer_expired) begin
            timeout_err <= 1'b1;
            state       <= S_HALT;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_cmd_dispatch.sv
// Directed bench for icache_cmd_dispatch: table of single records plus hand sequences for
// burst drop, FIFO full/wrap ordering, reset mid-command, and the cache watchdog.
module tb_icache_cmd_dispatch;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic                  clk;
  logic                  rst;
  logic                  print_req;
  logic [31:0]           issued_cnt;
  logic [31:0]           dropped_cnt;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  idle;
  logic                  timeout_err;

  icache_cmd_dispatch_if bus ();

  icache_cmd_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .print_req   (print_req),
    .issued_cnt  (issued_cnt),
    .dropped_cnt (dropped_cnt),
    .fifo_count  (fifo_count),
    .idle        (idle),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: counts strobes and print pulses, logs every issued command.
  int          wr_count = 0;
  int          print_cycles = 0;
  logic [2:0]  log_cmd [$];
  logic [59:0] log_addr[$];
  initial begin
    forever begin
      @(negedge clk);
      if (bus.c_write === 1'b1) begin
        wr_count++;
        log_cmd.push_back(bus.c_command);
        log_addr.push_back(bus.c_address);
      end
      if (print_req === 1'b1) print_cycles++;
    end
  end

  // Cache model. mode 0: ack the cycle after a strobe, busy 2 cycles; 1: always busy;
  // 2: go busy after a strobe and never finish.
  int   cm_mode = 0;
  int   busy = 0;
  logic wr_q;
  initial begin
    bus.c_processing = 1'b0;
    forever begin
      @(negedge clk);
      wr_q = bus.c_write;
      @(posedge clk);
      #1;
      if (cm_mode == 1) begin
        bus.c_processing = 1'b1;
      end else if (cm_mode == 2) begin
        if (wr_q) bus.c_processing = 1'b1;
      end else begin
        if (wr_q) busy = 2;
        else if (busy > 0) busy--;
        bus.c_processing = (busy > 0);
      end
    end
  end

  task automatic push(input logic [3:0] code, input logic [59:0] addr);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    bus.in_addr  = addr;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("push_ready", bus.in_ready, 1);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(idle && !bus.c_processing && busy == 0) && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    chk("idle_reached", idle, 1);
    @(posedge clk); #2;
  endtask

  task automatic wait_strobe(input string name);
    int n = 0;
    while (bus.c_write !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.c_write, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},    bus.in_ready, 1);
    chk({tag, "_idle"},        idle, 1);
    chk({tag, "_c_write"},     bus.c_write, 0);
    chk({tag, "_c_command"},   bus.c_command, 0);
    chk({tag, "_c_address"},   bus.c_address, 0);
    chk({tag, "_print_req"},   print_req, 0);
    chk({tag, "_issued_cnt"},  issued_cnt, 0);
    chk({tag, "_dropped_cnt"}, dropped_cnt, 0);
    chk({tag, "_fifo_count"},  fifo_count, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  typedef struct {
    logic [3:0]  code;
    logic [59:0] addr;
    bit          issue;
    logic [2:0]  cmd;
    int          prints;
    bit          drop;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          w0;
    int          p0;
    int          base;
    int          exp_issued;
    int          exp_dropped;
    logic [2:0]  last_cmd;
    logic [59:0] last_addr;

    vecs[0] = '{code: 4'd2, addr: 60'h0_0000_0012_3440, issue: 1, cmd: 3'd0, prints: 0, drop: 0};
    vecs[1] = '{code: 4'd0, addr: 60'h0_0000_0000_1000, issue: 0, cmd: 3'd0, prints: 0, drop: 1};
    vecs[2] = '{code: 4'd1, addr: 60'h0_0000_0000_2000, issue: 0, cmd: 3'd0, prints: 0, drop: 1};
    vecs[3] = '{code: 4'd3, addr: 60'h0_0000_0000_3000, issue: 0, cmd: 3'd0, prints: 0, drop: 1};
    vecs[4] = '{code: 4'd4, addr: 60'h0_0000_0000_4000, issue: 0, cmd: 3'd0, prints: 0, drop: 1};
    vecs[5] = '{code: 4'd2, addr: 60'hF_EDCB_A987_6543, issue: 1, cmd: 3'd0, prints: 0, drop: 0};
    vecs[6] = '{code: 4'd9, addr: 60'h0_0000_0000_9999, issue: 0, cmd: 3'd0, prints: 1, drop: 0};
    vecs[7] = '{code: 4'd8, addr: 60'h1_2345_6789_ABCD, issue: 1, cmd: 3'd3, prints: 0, drop: 0};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_code  = 4'd0;
    bus.in_addr  = 60'd0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #2;

    exp_issued  = 0;
    exp_dropped = 0;
    last_cmd    = 3'd0;
    last_addr   = 60'd0;

    // Single records, one at a time.
    for (int i = 0; i < 8; i++) begin
      w0 = wr_count;
      p0 = print_cycles;
      push(vecs[i].code, vecs[i].addr);
      wait_idle();
      if (vecs[i].issue) begin
        exp_issued++;
        last_cmd  = vecs[i].cmd;
        last_addr = vecs[i].addr;
      end
      if (vecs[i].drop) exp_dropped++;
      chk($sformatf("vec%0d_writes", i),    wr_count - w0, vecs[i].issue ? 1 : 0);
      chk($sformatf("vec%0d_prints", i),    print_cycles - p0, vecs[i].prints);
      chk($sformatf("vec%0d_issued", i),    issued_cnt, exp_issued);
      chk($sformatf("vec%0d_dropped", i),   dropped_cnt, exp_dropped);
      chk($sformatf("vec%0d_c_command", i), bus.c_command, last_cmd);
      chk($sformatf("vec%0d_c_address", i), bus.c_address, last_addr);
    end

    // Back-to-back unsupported codes followed by a READ.
    w0 = wr_count;
    push(4'd0, 60'h10);
    push(4'd1, 60'h11);
    push(4'd3, 60'h13);
    push(4'd4, 60'h14);
    push(4'd2, 60'h0_0000_0000_ABC0);
    wait_idle();
    exp_dropped += 4;
    exp_issued  += 1;
    chk("burst_writes",    wr_count - w0, 1);
    chk("burst_dropped",   dropped_cnt, exp_dropped);
    chk("burst_issued",    issued_cnt, exp_issued);
    chk("burst_c_command", bus.c_command, 0);
    chk("burst_c_address", bus.c_address, 60'h0_0000_0000_ABC0);

    // Fill the FIFO while the cache is busy, then drain across the pointer wrap.
    cm_mode = 1;
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < DEPTH; i++) push((i % 2) ? 4'd8 : 4'd2, 60'hA000 + 60'(i));
    chk("full_count",    fifo_count, DEPTH);
    chk("full_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_code  = 4'd2;
    bus.in_addr  = 60'hDEAD;
    repeat (3) @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    chk("full_extra_rejected", fifo_count, DEPTH);
    w0   = wr_count;
    base = log_addr.size();
    cm_mode = 0;
    wait_idle();
    exp_issued += DEPTH;
    chk("drain_writes", wr_count - w0, DEPTH);
    chk("drain_issued", issued_cnt, exp_issued);
    for (int i = 0; i < DEPTH; i++) begin
      if (base + i < log_addr.size()) begin
        chk($sformatf("drain%0d_addr", i), log_addr[base + i], 60'hA000 + 60'(i));
        chk($sformatf("drain%0d_cmd", i),  log_cmd[base + i], (i % 2) ? 3'd3 : 3'd0);
      end
    end

    // Reset while the command sits in WAIT_DONE.
    cm_mode = 2;
    push(4'd2, 60'h5555);
    wait_strobe("rstmid_strobe");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    check_reset_outputs("rstmid");
    rst = 1'b0;
    cm_mode = 0;
    w0 = wr_count;
    repeat (10) @(posedge clk);
    #2;
    chk("rstmid_no_write", wr_count - w0, 0);

    // Cache never completes: watchdog fires TIMEOUT cycles after the strobe edge.
    cm_mode = 2;
    push(4'd2, 60'h7777);
    wait_strobe("timeout_strobe");
    @(posedge clk);
    repeat (TIMEOUT - 1) @(posedge clk);
    #2;
    chk("timeout_early", timeout_err, 0);
    @(posedge clk); #2;
    chk("timeout_set", timeout_err, 1);
    w0 = wr_count;
    push(4'd8, 60'h8888);
    chk("halt_accepts", fifo_count, 1);
    repeat (20) @(posedge clk);
    #2;
    chk("halt_no_pop",   fifo_count, 1);
    chk("halt_no_write", wr_count - w0, 0);
    chk("halt_not_idle", idle, 0);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    cm_mode = 0;
    chk("halt_rst_timeout", timeout_err, 0);
    chk("halt_rst_count",   fifo_count, 0);
    chk("halt_rst_idle",    idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
